// File: rtl/round_pkg.sv
// round_pkg: shared round states and default match parameters for the sequencer and score decoder.
package round_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        WIN_HOLD  = 3'd2,
        LOSS_HOLD = 3'd3,
        OVER      = 3'd4
    } round_state_t;

    localparam int WIN_LIMIT_DEF   = 7;
    localparam int HOLD_CYCLES_DEF = 16;
    localparam int CNT_W_DEF       = 3;

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter timing the between-round playfield hold window.
module hold_timer #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic done_o
);

    localparam int W = $clog2(HOLD_CYCLES + 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (load_i)
            count_q <= W'(HOLD_CYCLES - 1);
        else if (count_q != '0)
            count_q <= count_q - 1'b1;
    end

    assign done_o = (count_q == '0) && !load_i;

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: gates play, counts the win streak, and holds the playfield in reset between rounds.
module round_sequencer
    import round_pkg::*;
#(
    parameter int WIN_LIMIT   = WIN_LIMIT_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             score_i,
    input  logic             hit_i,
    output logic             play_en_o,
    output logic             field_reset_o,
    output logic             win_pulse_o,
    output logic [CNT_W-1:0] win_count_o,
    output logic             match_over_o
);

    round_state_t     state_q;
    logic             start_q;
    logic             play_en_q;
    logic             field_reset_q;
    logic             win_pulse_q;
    logic [CNT_W-1:0] win_count_q;
    logic             match_over_q;
    logic             hold_done;

    wire start_rise = start_i & ~start_q;
    wire last_win   = ({1'b0, win_count_q} + 1'b1) == (CNT_W + 1)'(WIN_LIMIT);

    // Any round-ending event in PLAY arms the hold window for the following state.
    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_q == PLAY && (hit_i || score_i)),
        .done_o (hold_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b1;
            play_en_q     <= 1'b0;
            field_reset_q <= 1'b1;
            win_pulse_q   <= 1'b0;
            win_count_q   <= '0;
            match_over_q  <= 1'b0;
        end else begin
            start_q     <= start_i;
            win_pulse_q <= 1'b0;
            case (state_q)
                IDLE: if (start_rise) begin
                    state_q       <= PLAY;
                    play_en_q     <= 1'b1;
                    field_reset_q <= 1'b0;
                end
                PLAY: if (hit_i) begin
                    state_q       <= LOSS_HOLD;
                    win_count_q   <= '0;
                    play_en_q     <= 1'b0;
                    field_reset_q <= 1'b1;
                end else if (score_i) begin
                    state_q       <= last_win ? OVER : WIN_HOLD;
                    win_count_q   <= win_count_q + 1'b1;
                    win_pulse_q   <= 1'b1;
                    match_over_q  <= last_win;
                    play_en_q     <= 1'b0;
                    field_reset_q <= 1'b1;
                end
                WIN_HOLD, LOSS_HOLD: if (hold_done) begin
                    state_q       <= PLAY;
                    play_en_q     <= 1'b1;
                    field_reset_q <= 1'b0;
                end
                OVER: if (start_rise) begin
                    state_q      <= IDLE;
                    win_count_q  <= '0;
                    match_over_q <= 1'b0;
                end
                default: begin
                    state_q       <= IDLE;
                    play_en_q     <= 1'b0;
                    field_reset_q <= 1'b1;
                    win_count_q   <= '0;
                    match_over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign play_en_o     = play_en_q;
    assign field_reset_o = field_reset_q;
    assign win_pulse_o   = win_pulse_q;
    assign win_count_o   = win_count_q;
    assign match_over_o  = match_over_q;

endmodule
